arb_mux: RTL
============

# arb_mux

Parametrised N-channel arbitrated multiplexer with a registered output stage and valid/ready handshakes on every channel. It is the successor to the core's combinational select muxes for places where several requesters share one consumer, such as I-fetch, D-access and debug ports sharing the memory request path. Instead of an external select, it picks a channel by fixed-priority or round-robin arbitration. It also tags the output with the winning channel index.

## Interface
Parameters:
- DATA_WIDTH, default `DATA_WIDTH (32): payload width per channel.
- NUM_CH, default 3: number of input channels; legal range 2..16.
- RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_CH  per-channel request valid.
- in_data  in  NUM_CH x DATA_WIDTH  per-channel payload, unpacked array indexed by channel.
- in_ready  out  NUM_CH  per-channel accept; at most one bit set per cycle.
- out_valid  out  1  output register holds a valid beat.
- out_data  out  DATA_WIDTH  registered payload.
- out_ch  out  CH_W  index of the channel that supplied out_data; CH_W = max(1, $clog2(NUM_CH)).
- out_ready  in  1  downstream accept.
- flush  in  1  synchronous pipeline flush.

## Operation
- Single output register holding out_valid, out_data and out_ch.
- can_load = !out_valid | out_ready.
- Arbitration is combinational over in_valid.
  - RR_MODE=1: search starts at priority pointer ptr and wraps modulo NUM_CH; the first valid channel wins.
  - RR_MODE=0: the lowest-index valid channel wins; ptr is unused.
- grant[i] = winner(i) & can_load & !flush; in_ready = grant. Grant is one-hot or zero.
- Transfer on channel i when in_valid[i] & in_ready[i]. On a transfer, the register loads in_data[i] and i, and out_valid is set.
- When the output is consumed (out_valid & out_ready) with no new transfer, out_valid clears. out_data and out_ch hold their last values.
- Round-robin pointer: on a transfer from channel i, ptr <= (i+1) mod NUM_CH. With no transfer, ptr holds. The wrap from NUM_CH-1 goes to 0.
- flush has priority over everything:
  - next cycle out_valid=0;
  - in_ready=0 in the flush cycle;
  - ptr holds.
- Requesters must hold in_valid and in_data stable until accepted. The block does not check this.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready is combinational and is therefore 0 while out_valid=0 and no in_valid is set.
- Latency: an accepted beat appears on out_valid/out_data in the next cycle.
- Throughput: one beat per cycle when out_ready is held high (simultaneous consume and load).
- Stall: while out_valid & !out_ready, all in_ready=0 and the register holds.
- Combinational paths: out_ready -> in_ready, flush -> in_ready, in_valid -> in_ready. There is no path from in_data to any output except through the register.
- Reset asserted mid-transfer: state clears immediately (asynchronous). Any beat held in the register is lost. The first grant after rst_n deasserts uses ptr=0.

## Structure
- The shared types package holds DATA_WIDTH (the existing `DATA_WIDTH) and a ch_idx_t typedef sized by CH_W for reuse by downstream consumers that decode out_ch.
- One sub-module is natural: rr_arbiter (NUM_CH, RR_MODE). It takes req and ptr, returns one-hot grant and the encoded index, and is purely combinational.
- The top level holds the output register, the ptr register and the handshake logic.

## Test plan
- Reset, then idle: out_valid=0, out_data=0, out_ch=0 and in_ready=0 throughout; mid-run rst_n pulse clears a held beat immediately.
- NUM_CH=3, RR_MODE=1, out_ready=1, all channels valid with data 0xA0/0xB1/0xC2: out_ch sequence 0,1,2,0,… one per cycle; out_data follows 0xA0,0xB1,0xC2.
- RR_MODE=0, same stimulus: out_ch stays 0 every cycle and in_ready[1], in_ready[2] never assert.
- Channel 1 valid with 0x55 while out_ready=0 for 3 cycles after load: out_valid=1 and out_data=0x55 stable; in_ready=0 during the stall; on out_ready=1, the next beat loads in that same cycle.
- Round-robin wrap: only channel 2 granted, then channels 0 and 2 valid: channel 0 wins (ptr=0 after wrap).
- flush asserted with out_valid=1 and channel 0 valid: in_ready=0 in that cycle; next cycle out_valid=0 and ptr unchanged; the following cycle channel 0 is accepted.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared types for the arbitrated output mux and for downstream consumers
// that decode the channel tag (out_ch).
//   DATA_WIDTH : default payload width (the core-wide `DATA_WIDTH)
//   ch_width() : channel-index width for a given channel count, min 1 bit
//   ch_idx_t   : channel index type sized for the default channel count

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package arb_mux_pkg;

    localparam int unsigned DATA_WIDTH  = `DATA_WIDTH;
    localparam int unsigned DEF_NUM_CH  = 3;
    localparam int unsigned MIN_NUM_CH  = 2;
    localparam int unsigned MAX_NUM_CH  = 16;

    // max(1, clog2(n)): a two-channel mux still needs a one-bit tag
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 2) ? 1 : int'($clog2(n));
    endfunction

    // Round-robin successor of channel idx, wrapping at n
    function automatic int unsigned next_ch(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    localparam int unsigned DEF_CH_W = ch_width(DEF_NUM_CH);

    typedef logic [DEF_CH_W-1:0] ch_idx_t;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Registered output beat as seen by a consumer of the default configuration
    typedef struct packed {
        logic                  valid;
        ch_idx_t               ch;
        logic [DATA_WIDTH-1:0] data;
    } out_beat_t;

endpackage

// File: rtl/arb_mux_arbiter.sv
// rr_arbiter: purely combinational N-way arbiter.
//   req   : per-channel request
//   ptr   : round-robin start channel (ignored when RR_MODE=0)
//   grant : one-hot winner, zero when no request
//   idx   : encoded winner index (0 when no request)
//   found : any request present

module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter bit          RR_MODE = 1'b1,
    localparam int unsigned CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx,
    output logic              found
);

    int unsigned     w_start;
    int unsigned     w_pos;
    logic [CH_W-1:0] w_c;

    // Scan NUM_CH channels starting at w_start, wrapping; first requester wins
    always_comb begin
        w_start = RR_MODE ? 32'(ptr) : 32'd0;
        w_pos   = 0;
        w_c     = '0;
        grant   = '0;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_pos = w_start + k;
            if (w_pos >= NUM_CH) begin
                w_pos = w_pos - NUM_CH;
            end
            w_c = CH_W'(w_pos);
            if (!found && req[w_c]) begin
                found      = 1'b1;
                grant[w_c] = 1'b1;
                idx        = w_c;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-channel arbitrated multiplexer with one registered output stage.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : per-channel handshake (in_ready one-hot or zero)
//   in_data           : per-channel payload
//   out_valid/out_ready, out_data, out_ch : registered output beat + winner tag
//   flush             : synchronous flush; blocks acceptance and empties output

module arb_mux #(
    parameter int unsigned  DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned  NUM_CH     = 3,
    parameter bit           RR_MODE    = 1'b1,
    localparam int unsigned CH_W       = arb_mux_pkg::ch_width(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     in_valid,
    input  logic [DATA_WIDTH-1:0] in_data [NUM_CH],
    output logic [NUM_CH-1:0]     in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  out_ready,
    input  logic                  flush
);

    import arb_mux_pkg::*;

    logic [CH_W-1:0]       r_ptr;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CH_W-1:0]       r_out_ch;

    logic [NUM_CH-1:0]     w_grant;
    logic [CH_W-1:0]       w_idx;
    logic                  w_found;
    logic                  w_can_load;
    logic                  w_load;

    rr_arbiter #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .req   (in_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .found (w_found)
    );

    // Register can take a beat when empty or being drained this cycle
    assign w_can_load = ~r_out_valid | out_ready;
    // A grant is only a transfer because the arbiter only grants requesters
    assign w_load     = w_found & w_can_load & ~flush;
    assign in_ready   = w_load ? w_grant : '0;

    // Output beat register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_load) begin
                r_out_data <= in_data[w_idx];
                r_out_ch   <= w_idx;
                r_ptr      <= CH_W'(next_ch(32'(w_idx), NUM_CH));
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule
